// File: rtl/dds_phase_detector_if.sv
// I/Q sample stream in, phase / magnitude / frequency estimates out.
// The sample source takes the master side and the detector takes the slave side.
interface dds_phase_detector_if #(
  parameter int IQ_NUM      = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 14
);
  logic                                tvalid_i;
  logic [IQ_NUM-1:0][DATA_WIDTH-1:0]   tdata_i;
  logic                                tvalid_o;
  logic [PHASE_WIDTH-1:0]              phase_o;
  logic [DATA_WIDTH:0]                 mag_o;
  logic                                inc_valid_o;
  logic [PHASE_WIDTH-1:0]              phase_inc_o;
  logic                                freq_valid_o;
  logic [PHASE_WIDTH-1:0]              freq_o;

  modport master (
    output tvalid_i, tdata_i,
    input  tvalid_o, phase_o, mag_o, inc_valid_o, phase_inc_o, freq_valid_o, freq_o
  );

  modport slave (
    input  tvalid_i, tdata_i,
    output tvalid_o, phase_o, mag_o, inc_valid_o, phase_inc_o, freq_valid_o, freq_o
  );
endinterface

// File: rtl/dds_phase_detector.sv
// Vectoring-mode CORDIC turning I/Q samples into phase and magnitude. A phase
// differentiator and a block averager follow it and give frequency on the DDS phase_inc scale.
module dds_phase_detector #(
  parameter int IQ_NUM      = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 14,
  parameter int ITER        = 14,
  parameter int GUARD       = 3,
  parameter int AVG_LOG2    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dds_phase_detector_if.slave  bus
);
  localparam int XW = DATA_WIDTH + 2;
  localparam int ZW = PHASE_WIDTH + GUARD;
  localparam int AW = PHASE_WIDTH + AVG_LOG2;
  localparam logic [ZW-1:0] Z_PI       = {1'b1, {(ZW-1){1'b0}}};
  localparam logic [ZW-1:0] Z_HALF_LSB = ZW'(1) << (GUARD - 1);

  // Elaboration-time arctangent table, scaled so that 2^ZW is one full turn
  function automatic logic [ZW-1:0] atan_const(input int idx);
    real    r;
    integer v;
    r = $atan(2.0 ** (-idx)) * (2.0 ** ZW) / (2.0 * 3.14159265358979323846);
    v = $rtoi(r + 0.5);
    return v[ZW-1:0];
  endfunction

  logic signed [XW-1:0] x_reg  [0:ITER];
  logic signed [XW-1:0] y_reg  [0:ITER];
  logic        [ZW-1:0] z_reg  [0:ITER];
  logic signed [XW-1:0] x_next [0:ITER];
  logic signed [XW-1:0] y_next [0:ITER];
  logic        [ZW-1:0] z_next [0:ITER];
  logic                 v_reg    [0:ITER];
  logic                 zero_reg [0:ITER];

  logic signed [XW-1:0] i_ext;
  logic signed [XW-1:0] q_ext;

  assign i_ext = XW'($signed(bus.tdata_i[0]));
  assign q_ext = XW'($signed(bus.tdata_i[IQ_NUM-1]));

  // Fold the left half-plane onto the right so the micro-rotations only have to cover +/-90 degrees
  assign x_next[0] = i_ext[XW-1] ? -i_ext : i_ext;
  assign y_next[0] = i_ext[XW-1] ? -q_ext : q_ext;
  assign z_next[0] = i_ext[XW-1] ? Z_PI   : '0;

  genvar gi;
  generate
    for (gi = 0; gi < ITER; gi++) begin : g_stage
      localparam logic [ZW-1:0] ATAN = atan_const(gi);
      logic y_neg;
      assign y_neg         = y_reg[gi][XW-1];
      assign x_next[gi+1]  = y_neg ? x_reg[gi] - (y_reg[gi] >>> gi) : x_reg[gi] + (y_reg[gi] >>> gi);
      assign y_next[gi+1]  = y_neg ? y_reg[gi] + (x_reg[gi] >>> gi) : y_reg[gi] - (x_reg[gi] >>> gi);
      assign z_next[gi+1]  = y_neg ? z_reg[gi] - ATAN : z_reg[gi] + ATAN;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k <= ITER; k++) begin
        x_reg[k]    <= '0;
        y_reg[k]    <= '0;
        z_reg[k]    <= '0;
        v_reg[k]    <= 1'b0;
        zero_reg[k] <= 1'b0;
      end
    end else begin
      v_reg[0]    <= bus.tvalid_i;
      zero_reg[0] <= (i_ext == '0) && (q_ext == '0);
      for (int k = 0; k <= ITER; k++) begin
        x_reg[k] <= x_next[k];
        y_reg[k] <= y_next[k];
        z_reg[k] <= z_next[k];
      end
      for (int k = 1; k <= ITER; k++) begin
        v_reg[k]    <= v_reg[k-1];
        zero_reg[k] <= zero_reg[k-1];
      end
    end
  end

  logic [ZW-1:0] z_round;
  assign z_round = z_reg[ITER] + Z_HALF_LSB;

  // An all-zero input has no defined angle; report 0 rather than the summed table
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.tvalid_o <= 1'b0;
      bus.phase_o  <= '0;
      bus.mag_o    <= '0;
    end else begin
      bus.tvalid_o <= v_reg[ITER];
      bus.phase_o  <= zero_reg[ITER] ? '0 : z_round[ZW-1:GUARD];
      bus.mag_o    <= x_reg[ITER][DATA_WIDTH:0];
    end
  end

  logic [PHASE_WIDTH-1:0] prev_reg;
  logic                   prev_valid_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_reg        <= '0;
      prev_valid_reg  <= 1'b0;
      bus.inc_valid_o <= 1'b0;
      bus.phase_inc_o <= '0;
    end else begin
      bus.inc_valid_o <= 1'b0;
      if (bus.tvalid_o) begin
        if (prev_valid_reg) begin
          bus.phase_inc_o <= bus.phase_o - prev_reg;
          bus.inc_valid_o <= 1'b1;
        end
        prev_reg       <= bus.phase_o;
        prev_valid_reg <= 1'b1;
      end
    end
  end

  logic signed [AW-1:0]       acc_reg;
  logic signed [AW-1:0]       acc_sum;
  logic        [AVG_LOG2-1:0] cnt_reg;

  assign acc_sum = acc_reg + {{AVG_LOG2{bus.phase_inc_o[PHASE_WIDTH-1]}}, bus.phase_inc_o};

  // The closing increment is folded into the result so no sample is lost at the block boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_reg          <= '0;
      cnt_reg          <= '0;
      bus.freq_valid_o <= 1'b0;
      bus.freq_o       <= '0;
    end else begin
      bus.freq_valid_o <= 1'b0;
      if (bus.inc_valid_o) begin
        if (cnt_reg == '1) begin
          bus.freq_o       <= acc_sum[AW-1:AVG_LOG2];
          bus.freq_valid_o <= 1'b1;
          acc_reg          <= '0;
          cnt_reg          <= '0;
        end else begin
          acc_reg <= acc_sum;
          cnt_reg <= cnt_reg + AVG_LOG2'(1);
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{y_reg[ITER], x_reg[ITER][XW-1], z_round[GUARD-1:0]};

endmodule

// File: tb/tb_dds_phase_detector.sv
// Scoreboard bench for dds_phase_detector: a floating-point reference predicts phase, magnitude,
// increment and block mean for each sample, and the DUT outputs are matched in order.
module tb_dds_phase_detector;
  localparam int    DW      = 16;
  localparam int    PW      = 14;
  localparam int    LAT     = 16;
  localparam real   PI      = 3.14159265358979323846;
  localparam real   GAIN    = 1.646760258;
  localparam real   AMP     = 30000.0;
  localparam int    INC     = 3276;

  typedef struct {
    int cyc;
    int ph;
    int mag;
    int ptol;
    int mtol;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   inc_seen = 0;

  exp_t out_q[$];
  int   inc_q[$];
  int   freq_q[$];
  bit   have_prev;
  real  prev_p;
  real  blk_sum;
  int   blk_n;

  dds_phase_detector_if #(.IQ_NUM(2), .DATA_WIDTH(DW), .PHASE_WIDTH(PW)) bus ();

  dds_phase_detector #(
    .IQ_NUM(2), .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ITER(14), .GUARD(3), .AVG_LOG2(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // modw > 0 compares modulo 2^modw, for values that wrap around the phase circle
  task automatic check(input string tag, input int obs, input int expv, input int tol, input int modw);
    int d;
    int m;
    n_tests++;
    d = obs - expv;
    if (modw > 0) begin
      m = 1 << modw;
      d = ((d % m) + m) % m;
      if (d >= m / 2) d -= m;
    end
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, obs, expv, tol, cyc);
    end
  endtask

  task automatic push_sample(input int i, input int q, input int ptol, input int mtol);
    real  p;
    real  d;
    exp_t e;
    if (i == 0 && q == 0) p = 0.0;
    else begin
      p = $atan2(real'(q), real'(i)) * 16384.0 / (2.0 * PI);
      if (p < 0.0) p += 16384.0;
    end
    e.cyc  = cyc + LAT;
    e.ph   = int'(p) % 16384;
    e.mag  = int'(GAIN * $sqrt(real'(i) * real'(i) + real'(q) * real'(q)));
    e.ptol = ptol;
    e.mtol = mtol;
    out_q.push_back(e);
    if (have_prev) begin
      d = p - prev_p;
      if (d > 8192.0) d -= 16384.0;
      else if (d <= -8192.0) d += 16384.0;
      inc_q.push_back(int'(d));
      blk_sum += d;
      blk_n++;
      if (blk_n == 16) begin
        freq_q.push_back(int'(blk_sum / 16.0));
        blk_sum = 0.0;
        blk_n   = 0;
      end
    end
    prev_p    = p;
    have_prev = 1'b1;
  endtask

  task automatic drive(input int i, input int q, input int ptol, input int mtol);
    @(posedge clk);
    #1;
    bus.tvalid_i   = 1'b1;
    bus.tdata_i[0] = 16'(i);
    bus.tdata_i[1] = 16'(q);
    push_sample(i, q, ptol, mtol);
    $display("[TB] drive I=%0d Q=%0d at cycle %0d", i, q, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.tvalid_i = 1'b0;
    end
  endtask

  task automatic stream(input int n, input int gap, input bit neg, input int ph0);
    int  acc;
    int  i;
    int  q;
    real a;
    acc = ph0;
    for (int k = 0; k < n; k++) begin
      a = 2.0 * PI * real'(acc) / 16384.0;
      i = int'(AMP * $cos(a));
      q = int'(AMP * $sin(a));
      if (neg) q = -q;
      drive(i, q, 2, 12);
      if (gap > 0) idle(gap);
      acc = (acc + INC) % 16384;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.tvalid_i = 1'b0;
    #1;
    check("rst_tvalid_o", int'(bus.tvalid_o), 0, 0, 0);
    check("rst_inc_valid_o", int'(bus.inc_valid_o), 0, 0, 0);
    check("rst_freq_valid_o", int'(bus.freq_valid_o), 0, 0, 0);
    out_q.delete();
    inc_q.delete();
    freq_q.delete();
    have_prev = 1'b0;
    blk_sum   = 0.0;
    blk_n     = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   v;
    if (rst) begin
      inc_seen = 0;
    end else begin
      if (bus.tvalid_o) begin
        if (out_q.size() == 0) check("out_unexpected", 1, 0, 0, 0);
        else begin
          e = out_q.pop_front();
          check("latency", cyc, e.cyc, 0, 0);
          check("phase", int'(bus.phase_o), e.ph, e.ptol, PW);
          check("mag", int'(bus.mag_o), e.mag, e.mtol, 0);
          $display("[TB] out phase=%0d mag=%0d exp %0d/%0d", bus.phase_o, bus.mag_o, e.ph, e.mag);
        end
      end
      // Block check first: this cycle's increment belongs to the next block
      if (bus.freq_valid_o) begin
        check("block_len", inc_seen, 16, 0, 0);
        inc_seen = 0;
        if (freq_q.size() == 0) check("freq_unexpected", 1, 0, 0, 0);
        else begin
          v = freq_q.pop_front();
          check("freq", int'($signed(bus.freq_o)), v, 1, PW);
          $display("[TB] freq=%0d exp %0d", $signed(bus.freq_o), v);
        end
      end
      if (bus.inc_valid_o) begin
        inc_seen++;
        if (inc_q.size() == 0) check("inc_unexpected", 1, 0, 0, 0);
        else begin
          v = inc_q.pop_front();
          check("phase_inc", int'($signed(bus.phase_inc_o)), v, 2, PW);
          $display("[TB] inc=%0d exp %0d", $signed(bus.phase_inc_o), v);
        end
      end
    end
  end

  initial begin
    int sv_i[6];
    int sv_q[6];
    int sv_m[6];
    sv_i = '{0, 16384, 0, -16384, 0, -32768};
    sv_q = '{0, 0, 16384, 0, -16384, 0};
    sv_m = '{8, 8, 8, 8, 8, 12};
    have_prev = 1'b0;
    blk_sum   = 0.0;
    blk_n     = 0;

    // Reset held with valid input present: nothing may leak out
    rst            = 1'b1;
    bus.tvalid_i   = 1'b1;
    bus.tdata_i[0] = 16'(1000);
    bus.tdata_i[1] = 16'(500);
    repeat (10) @(posedge clk);
    #1;
    check("rst_tvalid_o", int'(bus.tvalid_o), 0, 0, 0);
    check("rst_phase_o", int'(bus.phase_o), 0, 0, 0);
    check("rst_mag_o", int'(bus.mag_o), 0, 0, 0);
    check("rst_inc_valid_o", int'(bus.inc_valid_o), 0, 0, 0);
    check("rst_phase_inc_o", int'(bus.phase_inc_o), 0, 0, 0);
    check("rst_freq_valid_o", int'(bus.freq_valid_o), 0, 0, 0);
    check("rst_freq_o", int'(bus.freq_o), 0, 0, 0);
    rst          = 1'b0;
    bus.tvalid_i = 1'b0;

    // Static vectors on the axes, the most negative I, and the zero vector
    for (int k = 0; k < 6; k++) drive(sv_i[k], sv_q[k], 1, sv_m[k]);
    idle(LAT + 4);
    do_reset(2);

    // Loopback tone, positive then negative frequency
    stream(40, 0, 1'b0, 10000);
    idle(LAT + 4);
    do_reset(2);
    stream(40, 0, 1'b1, 500);
    idle(LAT + 4);
    do_reset(2);

    // One valid cycle in three, crossing the phase wrap several times
    stream(30, 2, 1'b0, 15000);
    idle(LAT + 4);
    do_reset(2);

    // Reset with the pipeline full, then restart from a clean state
    stream(24, 0, 1'b0, 700);
    do_reset(3);
    stream(40, 0, 1'b0, 9000);
    idle(LAT + 9);

    check("out_drain", out_q.size(), 0, 0, 0);
    check("inc_drain", inc_q.size(), 0, 0, 0);
    check("freq_drain", freq_q.size(), 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
